// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states and owner encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating stall counter; expired_o flags the cycle whose stall count equals TIMEOUT.
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // TIMEOUT of zero means the counter may saturate but never aborts an access.
    assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory with per-access stall timeout.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise data has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              if_err_q, if_err_d, d_err_q, d_err_d;
    logic              pick;
    logic              in_gnt;
    logic              expired;

    assign in_gnt = (state_q == GNT_IF) || (state_q == GNT_D);

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (!in_gnt),
        .en_i      (in_gnt && !mem_ready),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        pick        = OWN_IF;

        if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            pick = ~owner_q;
`else
            pick = OWN_D;
`endif
        end else begin
            pick = d_req ? OWN_D : OWN_IF;
        end

        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d = pick;
                    if (pick == OWN_D) begin
                        state_d     = GNT_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                    end else begin
                        state_d     = GNT_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end
                end
            end
            GNT_IF, GNT_D: begin
                // A ready arriving on the expiry cycle still completes the access.
                if (mem_ready || expired) begin
                    state_d = RESP;
                    if (state_q == GNT_D) begin
                        d_rdata_d = mem_ready ? mem_rdata : '0;
                        d_err_d   = !mem_ready;
                    end else begin
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                        if_err_d   = !mem_ready;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_req   = in_gnt;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_ack     = (state_q == RESP) && (owner_q == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized transactions against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_ack, if_err, d_ack, d_err, mem_req, mem_we, busy, owner;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    bit          owner_m;
    logic [31:0] exp_rd [2];
    bit          exp_er [2];

    // Model of the arbitration rule: 1 = data wins, 0 = fetch wins.
    function automatic bit pick(input bit ri, input bit rd);
        if (ri && rd) begin
`ifdef MEM_ARB_RR_EN
            return !owner_m;
`else
            return 1'b1;
`endif
        end
        return rd;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input bit in_resp, input bit w);
        chk("if_ack", 64'(if_ack), 64'(in_resp && !w));
        chk("d_ack", 64'(d_ack), 64'(in_resp && w));
        chk("if_rdata", 64'(if_rdata), 64'(exp_rd[0]));
        chk("if_err", 64'(if_err), 64'(exp_er[0]));
        chk("d_rdata", 64'(d_rdata), 64'(exp_rd[1]));
        chk("d_err", 64'(d_err), 64'(exp_er[1]));
    endtask

    // One transaction starting from IDLE; stall = cycles of mem_ready=0 before ready.
    task automatic txn(input bit ri, input bit rd, input bit we,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw,
                       input logic [3:0] be, input int stall, input logic [31:0] rdv,
                       input bit keep, input int drop_at);
        bit          w, tmo;
        int          n_gnt;
        logic [31:0] ea;
        logic [3:0]  eb;
        bit          ewe;
        if_req = ri; d_req = rd; d_we = we;
        if_addr = ia; d_addr = da; d_wdata = dw; d_be = be;
        w = pick(ri, rd);
        if (w) begin ewe = we;   ea = da; eb = be;    end
        else   begin ewe = 1'b0; ea = ia; eb = 4'hF; end
        tmo   = stall > TO;
        n_gnt = tmo ? TO + 1 : stall + 1;
        @(posedge clk); #1;
        owner_m = w;
        for (int k = 0; k < n_gnt; k++) begin
            chk("mem_req", 64'(mem_req), 64'(1));
            chk("busy", 64'(busy), 64'(1));
            chk("owner", 64'(owner), 64'(w));
            chk("mem_we", 64'(mem_we), 64'(ewe));
            chk("mem_addr", 64'(mem_addr), 64'(ea));
            chk("mem_be", 64'(mem_be), 64'(eb));
            if (w) chk("mem_wdata", 64'(mem_wdata), 64'(dw));
            check_ports(1'b0, w);
            mem_ready = (k == stall);
            mem_rdata = (k == stall) ? rdv : $urandom;
            if (k == drop_at) begin if_req = 1'b0; d_req = 1'b0; end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        exp_rd[w] = tmo ? 32'h0 : rdv;
        exp_er[w] = tmo;
        chk("mem_req_resp", 64'(mem_req), 64'(0));
        chk("busy_resp", 64'(busy), 64'(1));
        chk("owner_resp", 64'(owner), 64'(w));
        check_ports(1'b1, w);
        if (!keep) begin if_req = 1'b0; d_req = 1'b0; end
        @(posedge clk); #1;
        chk("busy_idle", 64'(busy), 64'(0));
        chk("owner_idle", 64'(owner), 64'(w));
        check_ports(1'b0, w);
    endtask

    initial begin
        bit ri, rd;
        rstn = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
        owner_m = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0; exp_er[0] = 1'b0; exp_er[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_owner", 64'(owner), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        check_ports(1'b0, 1'b0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // fetch, immediate ready
        txn(1, 0, 0, 32'h40, 0, 0, 0, 0, 32'h00500093, 0, -1);
        // store with 3-cycle stall
        txn(0, 1, 1, 0, 32'h100, 32'hDEADBEEF, 4'b0011, 3, 32'h12345678, 0, -1);
        // simultaneous requests held across transactions
        txn(1, 1, 0, 32'h200, 32'h300, 0, 4'hF, 1, 32'hA1, 1, -1);
        txn(1, 1, 0, 32'h204, 32'h304, 0, 4'hF, 0, 32'hA2, 1, -1);
        txn(1, 1, 0, 32'h208, 32'h308, 0, 4'hF, 2, 32'hA3, 0, -1);
        // timeout with ready never asserted
        txn(1, 0, 0, 32'h80, 0, 0, 0, 1000, 32'hFFFF, 0, -1);
        // data requester drops req mid-grant
        txn(0, 1, 0, 0, 32'h500, 0, 4'hF, 3, 32'hCAFE0001, 0, 1);

        // async reset during GNT_D
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h77; d_be = 4'h1;
        @(posedge clk); #1;
        chk("pre_rst_owner", 64'(owner), 64'(1));
        chk("pre_rst_mem_req", 64'(mem_req), 64'(1));
        #2 rstn = 1'b0;
        #1;
        d_req = 1'b0;
        owner_m = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0; exp_er[0] = 1'b0; exp_er[1] = 1'b0;
        chk("rst_mid_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_owner", 64'(owner), 64'(0));
        chk("rst_mid_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mid_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mid_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_mid_mem_be", 64'(mem_be), 64'(0));
        check_ports(1'b0, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        txn(1, 0, 0, 32'h44, 0, 0, 0, 1, 32'h13, 0, -1);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            ri = 1'($urandom);
            rd = 1'($urandom);
            if (!ri && !rd) ri = 1'b1;
            txn(ri, rd, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                $urandom, 4'($urandom), int'($urandom_range(0, 6)), $urandom,
                1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port unified memory between the core's instruction-fetch requester and its load/store (data) requester. It converts two request/acknowledge ports into one held-request memory port. It tracks which requester owns the memory, and it aborts memory accesses that stall past a programmable timeout. It sits between the fetch and execute stages and the memory model, replacing each stage's private memory array.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 255, maximum grant cycles without `mem_ready` before abort; 0 disables the timeout
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until `if_ack`
- if_addr  in  ADDR_W  fetch byte address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_rdata  out  DATA_W  fetch read data, valid with `if_ack`
- if_err  out  1  fetch timed out, valid with `if_ack`
- d_req  in  1  data request, held until `d_ack`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  load data, valid with `d_ack`
- d_err  out  1  data timed out, valid with `d_ack`
- mem_req  out  1  memory request, held until `mem_ready`
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  memory command fields
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  DATA_W  read data, valid when `mem_ready`=1
- busy  out  1  the FSM is not in IDLE
- owner  out  1  current/last grant: 0 = fetch, 1 = data

## Operation
- States: IDLE, GNT_IF, GNT_D, RESP.
- IDLE: sample `if_req` and `d_req`.
  - If neither is set, stay in IDLE.
  - If one is set, move to that requester's grant state.
  - If both are set, the arbitration policy chooses (see Configuration).
  - On entering a grant state, latch the command fields from the winner into the `mem_*` registers. Fetch grants set `mem_we`=0 and `mem_be`=all ones.
- GNT_x: drive `mem_req`=1 with stable fields.
  - On `mem_ready`=1: capture `mem_rdata` into the winner's rdata register, set err=0, go to RESP.
  - If the timeout counter reaches TIMEOUT first: drop `mem_req`, set rdata=0 and err=1, go to RESP.
- RESP: pulse the winner's ack for exactly one cycle, then return to IDLE. The other port's ack stays 0.
- The owner never changes during GNT_x or RESP. A requester that drops `req` mid-grant is ignored: the access completes and ack still pulses.
- Requesters must deassert `req` or present a new command by the edge that ends the ack cycle. A `req` seen in IDLE is always a new transaction.
- Timeout counter: cleared on entering GNT_x, incremented each GNT_x cycle with `mem_ready`=0, saturating. With TIMEOUT=0 it never fires.
- Asynchronous reset, mid-operation included, forces IDLE immediately. All outputs go to 0: `mem_req`, acks, errs, rdata, `mem_*` fields, `busy`, `owner`. The counter clears. An in-flight memory access is abandoned.

## Timing
- `req` high at edge N in IDLE → `mem_req` high in cycle N+1.
- `mem_ready` sampled at edge M → ack high in cycle M+1.
- Minimum latency from `req` to ack is 2 cycles. Back-to-back throughput is one access per 3 cycles (IDLE, GNT, RESP).
- `if_rdata`/`d_rdata` and the errs hold their values until that port's next RESP.
- A timeout fires on the edge where the stall count equals TIMEOUT: TIMEOUT+1 cycles of `mem_req`, then ack.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a simultaneous request, the requester opposite to `owner` wins. After reset `owner`=0, so the first simultaneous request goes to data.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always wins simultaneous requests. `owner` is still reported.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE, GNT_IF, GNT_D, RESP), owner constants OWN_IF=1'b0 and OWN_D=1'b1.
- One sub-module, `mem_arb_timer`: saturating stall counter with clear, enable, and a `expired` output compared against TIMEOUT.

## Test plan
- Fetch only: `if_addr`=0x40; memory answers with `mem_ready` in the first grant cycle, `mem_rdata`=0x00500093 → `if_ack` 2 cycles after `if_req`, `if_rdata`=0x00500093, `if_err`=0, `d_ack` stays 0.
- Store: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_be`=4'b0011, 3-cycle memory stall → `mem_*` fields match the command and stay stable for 4 cycles; `d_ack` pulses once with `d_err`=0.
- Simultaneous `if_req` and `d_req`, each held through 2 transactions → with RR_EN the grants go D, IF; without RR_EN they go D, D, then IF.
- Timeout: TIMEOUT=4, `mem_ready` tied 0 → `mem_req` high for 5 cycles, then drops; `if_ack`=1 with `if_err`=1 and `if_rdata`=0.
- `rstn` pulled low during GNT_D → `mem_req`, `busy`, and `owner` go to 0 before the next edge; after release, a fresh `if_req` completes normally.
- `d_req` dropped mid-grant → the memory access still completes and `d_ack` pulses once.
